// File: rtl/game_round_sequencer_pkg.sv
// Shared types and widths for the round sequencer and the blocks that
// consume its outputs (wall datapath, HUD overlay).
package game_round_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAYING   = 3'd2,
    ST_CLEAR     = 3'd3,
    ST_HIT       = 3'd4,
    ST_WON       = 3'd5,
    ST_LOST      = 3'd6
  } state_e;

  localparam int STATE_W = 3;
  localparam int ROUND_W = 3;      // displayed round count
  localparam int ROUND_CNT_W = 4;  // internal round counter, MAX_ROUNDS up to 15
  localparam int LIVES_W = 3;
  localparam int WIDX_W  = 4;
  localparam int FPT_W   = 4;
  localparam int TMR_W   = 8;

endpackage

// File: rtl/game_round_sequencer_if.sv
// Control/status bundle between the round sequencer and its surroundings.
//   start_in, new_frame_in, collision_in, wall_done_in : requests into the FSM
//   state_out .. countdown_out                          : registered FSM status
// slave  : the sequencer side.
// master : the side driving requests and observing status.
interface game_round_sequencer_if;
  import game_round_sequencer_pkg::*;

  logic               start_in;
  logic               new_frame_in;
  logic               collision_in;
  logic               wall_done_in;
  logic [STATE_W-1:0] state_out;
  logic [WIDX_W-1:0]  wall_idx_out;
  logic [FPT_W-1:0]   frames_per_tick_out;
  logic               wall_run_out;
  logic               wall_rst_out;
  logic [ROUND_W-1:0] round_out;
  logic [LIVES_W-1:0] lives_out;
  logic [TMR_W-1:0]   countdown_out;

  modport slave (
    input  start_in, new_frame_in, collision_in, wall_done_in,
    output state_out, wall_idx_out, frames_per_tick_out, wall_run_out,
           wall_rst_out, round_out, lives_out, countdown_out
  );

  modport master (
    output start_in, new_frame_in, collision_in, wall_done_in,
    input  state_out, wall_idx_out, frames_per_tick_out, wall_run_out,
           wall_rst_out, round_out, lives_out, countdown_out
  );
endinterface

// File: rtl/game_round_sequencer_frame_timer.sv
// Phase timer counting frames rather than cycles.
//   load_i/load_val_i : preset count (wins over a same-cycle frame pulse)
//   new_frame_in      : decrements a non-zero count
//   cnt_o             : remaining frames, for display
//   expire_o          : frame pulse arriving while the count is already 0
module game_round_sequencer_frame_timer
  import game_round_sequencer_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         new_frame_in,
  output logic [W-1:0] cnt_o,
  output logic         expire_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                            cnt_q <= '0;
    else if (load_i)                       cnt_q <= load_val_i;
    else if (new_frame_in && cnt_q != '0)  cnt_q <= cnt_q - W'(1);
  end

  // A load of N-1 therefore expires on the N-th frame pulse.
  assign expire_o = new_frame_in && (cnt_q == '0);
  assign cnt_o    = cnt_q;
endmodule

// File: rtl/game_round_sequencer.sv
// Round scheduler for the hole-in-the-wall game: countdown, play, result
// phases, lives/score/wall/speed bookkeeping, wall depth reset pulses.
//   clk_in, rst_in : clock, async active-high reset
//   bus            : requests in / registered status out (see interface)
module game_round_sequencer
  import game_round_sequencer_pkg::*;
#(
  parameter int NUM_WALLS             = 10,
  parameter int MAX_ROUNDS            = 5,
  parameter int START_LIVES           = 3,
  parameter int START_FRAMES_PER_TICK = 15,
  parameter int MIN_FRAMES_PER_TICK   = 3,
  parameter int SPEEDUP_STEP          = 2,
  parameter int COUNTDOWN_FRAMES      = 180,
  parameter int RESULT_FRAMES         = 60
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  game_round_sequencer_if.slave  bus
);
  localparam logic [STATE_W-1:0] S_IDLE      = ST_IDLE;
  localparam logic [STATE_W-1:0] S_COUNTDOWN = ST_COUNTDOWN;
  localparam logic [STATE_W-1:0] S_PLAYING   = ST_PLAYING;
  localparam logic [STATE_W-1:0] S_CLEAR     = ST_CLEAR;
  localparam logic [STATE_W-1:0] S_HIT       = ST_HIT;
  localparam logic [STATE_W-1:0] S_WON       = ST_WON;
  localparam logic [STATE_W-1:0] S_LOST      = ST_LOST;

  localparam logic [TMR_W-1:0]       CD_LOAD    = TMR_W'(COUNTDOWN_FRAMES - 1);
  localparam logic [TMR_W-1:0]       RES_LOAD   = TMR_W'(RESULT_FRAMES - 1);
  localparam logic [FPT_W-1:0]       FPT_START  = FPT_W'(START_FRAMES_PER_TICK);
  localparam logic [FPT_W-1:0]       FPT_MIN    = FPT_W'(MIN_FRAMES_PER_TICK);
  localparam logic [FPT_W-1:0]       FPT_STEP   = FPT_W'(SPEEDUP_STEP);
  // Subtracting is safe only from at least floor+step; below that, clamp.
  localparam logic [FPT_W:0]         FPT_SAT    = (FPT_W+1)'(MIN_FRAMES_PER_TICK + SPEEDUP_STEP);
  localparam logic [LIVES_W-1:0]     LIVES_INIT = LIVES_W'(START_LIVES);
  localparam logic [WIDX_W-1:0]      WIDX_LAST  = WIDX_W'(NUM_WALLS - 1);
  localparam logic [ROUND_CNT_W-1:0] ROUND_WIN  = ROUND_CNT_W'(MAX_ROUNDS);

  logic [STATE_W-1:0]     state_q, state_d;
  logic [ROUND_CNT_W-1:0] round_q, round_d;
  logic [LIVES_W-1:0]     lives_q, lives_d;
  logic [WIDX_W-1:0]      widx_q, widx_d;
  logic [FPT_W-1:0]       fpt_q, fpt_d;
  logic                   wall_rst_q, wall_rst_d;
  logic                   wall_run_q;

  logic                   tmr_load, tmr_exp;
  logic [TMR_W-1:0]       tmr_val, tmr_cnt;

  game_round_sequencer_frame_timer #(.W(TMR_W)) u_frame_timer (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .load_i       (tmr_load),
    .load_val_i   (tmr_val),
    .new_frame_in (bus.new_frame_in),
    .cnt_o        (tmr_cnt),
    .expire_o     (tmr_exp)
  );

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    lives_d    = lives_q;
    widx_d     = widx_q;
    fpt_d      = fpt_q;
    wall_rst_d = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = CD_LOAD;
    case (state_q)
      S_IDLE, S_WON, S_LOST: if (bus.start_in) begin
        state_d    = S_COUNTDOWN;
        round_d    = '0;
        lives_d    = LIVES_INIT;
        widx_d     = '0;
        fpt_d      = FPT_START;
        tmr_load   = 1'b1;
        wall_rst_d = 1'b1;
      end
      S_COUNTDOWN: if (tmr_exp) begin
        state_d    = S_PLAYING;
        wall_rst_d = 1'b1;
      end
      S_PLAYING: begin
        // collision wins over a same-cycle wall_done
        if (bus.collision_in) begin
          state_d  = S_HIT;
          lives_d  = lives_q - LIVES_W'(1);
          tmr_load = 1'b1;
          tmr_val  = RES_LOAD;
        end else if (bus.wall_done_in) begin
          state_d  = S_CLEAR;
          round_d  = round_q + ROUND_CNT_W'(1);
          tmr_load = 1'b1;
          tmr_val  = RES_LOAD;
        end
      end
      S_HIT: if (tmr_exp) begin
        if (lives_q == '0) state_d = S_LOST;
        else begin
          state_d    = S_COUNTDOWN;
          tmr_load   = 1'b1;
          wall_rst_d = 1'b1;
        end
      end
      S_CLEAR: if (tmr_exp) begin
        if (round_q == ROUND_WIN) state_d = S_WON;
        else begin
          widx_d     = (widx_q == WIDX_LAST) ? '0 : widx_q + WIDX_W'(1);
          fpt_d      = ({1'b0, fpt_q} >= FPT_SAT) ? fpt_q - FPT_STEP : FPT_MIN;
          state_d    = S_COUNTDOWN;
          tmr_load   = 1'b1;
          wall_rst_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      round_q    <= '0;
      lives_q    <= LIVES_INIT;
      widx_q     <= '0;
      fpt_q      <= FPT_START;
      wall_rst_q <= 1'b0;
      wall_run_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      lives_q    <= lives_d;
      widx_q     <= widx_d;
      fpt_q      <= fpt_d;
      wall_rst_q <= wall_rst_d;
      wall_run_q <= (state_d == S_PLAYING);
    end
  end

  assign bus.state_out           = state_q;
  assign bus.wall_idx_out        = widx_q;
  assign bus.frames_per_tick_out = fpt_q;
  assign bus.wall_run_out        = wall_run_q;
  assign bus.wall_rst_out        = wall_rst_q;
  // Display shows the low bits; the full count decides the win.
  assign bus.round_out           = round_q[ROUND_W-1:0];
  assign bus.lives_out           = lives_q;
  assign bus.countdown_out       = tmr_cnt;
endmodule
